// File: rtl/fsm_eg_pkg.sv
// Shared codes and transition function for the two-input example FSM
// and its transmit-side driver.
package fsm_eg_pkg;

  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;
  localparam logic [1:0] S2 = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRIVE = 2'b01,
    CHECK = 2'b10,
    RESP  = 2'b11
  } drv_state_t;

  // Target transition; the unused code 11 falls back to S0.
  function automatic logic [1:0] next_state(
    input logic [1:0] s,
    input logic       a,
    input logic       b
  );
    logic [1:0] n;
    n = S0;
    case (s)
      S0:      n = !a ? S0 : (b ? S2 : S1);
      S1:      n = a ? S0 : S1;
      default: n = S0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/fsm_eg_model.sv
// Combinational reference of the target FSM: next state plus expected
// Mealy y0 and Moore y1. Ports: state, a, b in; nxt, y0_exp, y1_exp out.
module fsm_eg_model
  import fsm_eg_pkg::*;
(
  input  logic [1:0] state,
  input  logic       a,
  input  logic       b,
  output logic [1:0] nxt,
  output logic       y0_exp,
  output logic       y1_exp
);

  assign nxt    = next_state(state, a, b);
  assign y1_exp = (state == S0) || (state == S1);
  assign y0_exp = (state == S0) && a && b;

endmodule

// File: rtl/fsm_eg_driver.sv
// Command-driven stimulus generator for the example FSM with a shadow
// copy of its state. Ports: clk, rst; cmd_valid/ready, cmd_a, cmd_b,
// cmd_len in; a, b drive out; y0, y1 observed; rsp_valid/ready, rsp_ok,
// rsp_state, err_cnt out. Output checking is built only when
// FSM_DRV_CHECK_EN is defined; otherwise rsp_ok=1 and err_cnt=0.
module fsm_eg_driver
  import fsm_eg_pkg::*;
#(
  parameter int LEN_W = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_a,
  input  logic             cmd_b,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             a,
  output logic             b,
  input  logic             y0,
  input  logic             y1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_ok,
  output logic [1:0]       rsp_state,
  output logic [ERR_W-1:0] err_cnt
);

  drv_state_t       st;
  drv_state_t       st_nx;
  logic [LEN_W-1:0] cnt;
  logic [1:0]       shadow;
  logic [1:0]       shadow_nx;
  logic             y0_exp;
  logic             y1_exp;
  logic             last;

  fsm_eg_model u_model (
    .state  (shadow),
    .a      (a),
    .b      (b),
    .nxt    (shadow_nx),
    .y0_exp (y0_exp),
    .y1_exp (y1_exp)
  );

  assign last = (cnt == '0);

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE:  if (cmd_valid) st_nx = DRIVE;
      DRIVE: if (last) st_nx = CHECK;
      CHECK: st_nx = RESP;
      RESP:  if (rsp_ready) st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= IDLE;
      cnt    <= '0;
      a      <= 1'b0;
      b      <= 1'b0;
      shadow <= S0;
    end else begin
      st <= st_nx;
      if (st == IDLE && cmd_valid) begin
        a   <= cmd_a;
        b   <= cmd_b;
        cnt <= cmd_len;
      end
      if (st == DRIVE) begin
        // Target FSM samples a/b on this same edge.
        shadow <= shadow_nx;
        if (last) begin
          a <= 1'b0;
          b <= 1'b0;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  assign cmd_ready = (st == IDLE);
  assign rsp_valid = (st == RESP);
  assign rsp_state = shadow;

`ifdef FSM_DRV_CHECK_EN
  logic             mis;
  logic             ok;
  logic [ERR_W-1:0] err;

  assign mis = (y0 != y0_exp) || (y1 != y1_exp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ok  <= 1'b1;
      err <= '0;
    end else begin
      if (st == IDLE && cmd_valid) begin
        ok <= 1'b1;
      end else if ((st == DRIVE || st == CHECK) && mis) begin
        ok <= 1'b0;
      end
      if (mis && err != '1) begin
        err <= err + 1'b1;
      end
    end
  end

  assign rsp_ok  = ok;
  assign err_cnt = err;
`else
  logic unused_obs;
  assign unused_obs = ^{y0, y1, y0_exp, y1_exp};
  assign rsp_ok     = 1'b1;
  assign err_cnt    = '0;
`endif

endmodule

// File: tb/tb_fsm_eg_driver.sv
// Bench: driver plus target FSM on shared clk/rst, vector table with
// response scoreboard and hand-written reset/error sequences.
module tb_fsm_eg_driver;

`ifdef FSM_DRV_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_a;
  logic       cmd_b;
  logic [3:0] cmd_len;
  logic       rsp_ready;
  logic       cmd_ready;
  logic       a;
  logic       b;
  logic       rsp_valid;
  logic       rsp_ok;
  logic [1:0] rsp_state;
  logic [7:0] err_cnt;
  logic       unused_rdy2;
  logic       unused_a2;
  logic       unused_b2;
  logic       unused_vld2;
  logic [1:0] unused_st2;
  logic       rsp_ok2;
  logic [1:0] err_cnt2;
  logic       y0;
  logic       y1;
  logic       force_y1;
  logic [1:0] t_st;

  int n_chk;
  int n_fail;

  fsm_eg_driver #(.LEN_W(4), .ERR_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_len(cmd_len),
    .a(a), .b(b), .y0(y0), .y1(y1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_ok(rsp_ok), .rsp_state(rsp_state),
    .err_cnt(err_cnt)
  );

  fsm_eg_driver #(.LEN_W(4), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(unused_rdy2),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_len(cmd_len),
    .a(unused_a2), .b(unused_b2), .y0(y0), .y1(y1),
    .rsp_valid(unused_vld2), .rsp_ready(rsp_ready),
    .rsp_ok(rsp_ok2), .rsp_state(unused_st2),
    .err_cnt(err_cnt2)
  );

  // Target FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) t_st <= 2'b00;
    else begin
      case (t_st)
        2'b00:   t_st <= !a ? 2'b00 : (b ? 2'b10 : 2'b01);
        2'b01:   t_st <= a ? 2'b00 : 2'b01;
        default: t_st <= 2'b00;
      endcase
    end
  end

  assign y1 = force_y1 ? 1'b0 : (t_st[1] == 1'b0);
  assign y0 = (t_st == 2'b00) && a && b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] st;
    logic       ok;
  } rsp_t;

  rsp_t sb[$];

  typedef struct {
    bit         rst_b;
    bit         a;
    bit         b;
    logic [3:0] len;
    int         hold;
    logic [1:0] st;
    bit         ok;
    bit         y0;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_cmd(input bit ca, input bit cb,
                        input logic [3:0] len, input int hold,
                        input int nforce, input bit y0e,
                        input logic [1:0] st, input bit ok);
    int   n;
    rsp_t r;
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_a     = ca;
    cmd_b     = cb;
    cmd_len   = len;
    cmd_valid = 1'b1;
    @(posedge clk);
    sb.push_back('{st: st, ok: ok});
    #1;
    cmd_valid = 1'b0;
    force_y1  = (nforce > 0);
    chk("a_drive", a, ca);
    chk("b_drive", b, cb);
    chk("y0_drive", y0, y0e);
    chk("cmd_ready_busy", cmd_ready, 0);
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      force_y1 = (n < nforce);
    end
    force_y1 = 1'b0;
    chk("rsp_latency", n, 32'(len) + 2);
    if (rsp_valid) begin
      r = sb.pop_front();
      chk("rsp_state", rsp_state, r.st);
      chk("rsp_ok", rsp_ok, r.ok);
      chk("a_in_resp", {a, b}, 0);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        chk("hold_valid", rsp_valid, 1);
        chk("hold_state", rsp_state, r.st);
        chk("hold_ok", rsp_ok, r.ok);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      chk("rsp_done", rsp_valid, 0);
      chk("cmd_ready_back", cmd_ready, 1);
    end else begin
      do_reset();
    end
  endtask

  initial begin
    int n;
    n_chk     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_a     = 1'b0;
    cmd_b     = 1'b0;
    cmd_len   = 4'd0;
    rsp_ready = 1'b0;
    force_y1  = 1'b0;

    vt[0] = '{rst_b: 1, a: 1, b: 0, len: 4'd0, hold: 0,
              st: 2'b01, ok: 1'b1, y0: 1'b0};
    vt[1] = '{rst_b: 0, a: 0, b: 1, len: 4'd15, hold: 5,
              st: 2'b01, ok: 1'b1, y0: 1'b0};
    vt[2] = '{rst_b: 1, a: 1, b: 1, len: 4'd0, hold: 0,
              st: 2'b10, ok: 1'b1, y0: 1'b1};
    vt[3] = '{rst_b: 0, a: 0, b: 0, len: 4'd0, hold: 0,
              st: 2'b00, ok: !CHK, y0: 1'b0};
    vt[4] = '{rst_b: 1, a: 1, b: 0, len: 4'd2, hold: 2,
              st: 2'b01, ok: 1'b1, y0: 1'b0};
    vt[5] = '{rst_b: 0, a: 1, b: 0, len: 4'd0, hold: 0,
              st: 2'b00, ok: 1'b1, y0: 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_ab", {a, b}, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_ok", rsp_ok, 1);
    chk("rst_rsp_state", rsp_state, 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      if (vt[i].rst_b) do_reset();
      do_cmd(vt[i].a, vt[i].b, vt[i].len, vt[i].hold, 0,
             vt[i].y0, vt[i].st, vt[i].ok);
    end

    // Reset while a response is pending
    do_reset();
    @(negedge clk);
    cmd_a     = 1'b1;
    cmd_b     = 1'b0;
    cmd_len   = 4'd1;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    force_y1  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    force_y1 = 1'b0;
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t1_rsp_seen", rsp_valid, 1);
    chk("t1_ok_pre", rsp_ok, !CHK);
    chk("t1_err_pre", err_cnt, CHK ? 2 : 0);
    rst = 1'b1;
    #1;
    chk("t1_ab", {a, b}, 0);
    chk("t1_cmd_ready", cmd_ready, 1);
    chk("t1_rsp_valid", rsp_valid, 0);
    chk("t1_rsp_ok", rsp_ok, 1);
    chk("t1_rsp_state", rsp_state, 0);
    chk("t1_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // Forced Moore mismatches and counter saturation
    do_reset();
    do_cmd(0, 0, 4'd3, 0, 3, 0, 2'b00, !CHK);
    chk("t5_err3", err_cnt, CHK ? 3 : 0);
    chk("t5_err3_w2", err_cnt2, CHK ? 3 : 0);
    chk("t5_ok_w2", rsp_ok2, !CHK);
    do_reset();
    do_cmd(0, 0, 4'd7, 0, 5, 0, 2'b00, !CHK);
    chk("t5_err5", err_cnt, CHK ? 5 : 0);
    chk("t5_sat_w2", err_cnt2, CHK ? 3 : 0);

    // Reset in the middle of a long drive
    do_reset();
    @(negedge clk);
    cmd_a     = 1'b1;
    cmd_b     = 1'b1;
    cmd_len   = 4'd7;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_state_pre", rsp_state, 2'b10);
    rst = 1'b1;
    #1;
    chk("t6_ab", {a, b}, 0);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_cmd_ready", cmd_ready, 1);
    chk("t6_shadow", rsp_state, 0);
    @(posedge clk);
    #1;
    chk("t6_ab_held", {a, b}, 0);
    @(negedge clk);
    rst = 1'b0;
    do_cmd(1, 0, 4'd0, 0, 0, 0, 2'b01, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
